// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Multi-key held-key tracker between a PS/2 byte receiver and game logic.
//   It decodes PS/2 set-2 make, break and E0-extended sequences and keeps a
//   table of up to SLOTS held keys. Press and release events are one-cycle
//   pulses carrying a 9-bit code {ext, scan[7:0]}.
//
//   Build option: define TYPEMATIC_FILTER_EN to make repeated makes of an
//   already-held key silent. When it is undefined, each repeat pulses
//   press_pulse.
//
// Ports
//   Clock          in   system clock, posedge
//   reset          in   asynchronous active-low reset
//   byte_valid     in   strobe: byte_data holds a new received byte
//   byte_data      in   received PS/2 byte
//   clear          in   synchronous flush of the table and the decoder
//   held_codes     out  slot i code at [9i+8:9i]; bit 8 = E0-extended
//   held_valid     out  slot i occupied
//   any_held       out  OR of held_valid
//   press_pulse    out  key entered the table (or typematic repeat)
//   release_pulse  out  key removed from the table
//   event_code     out  code of the latest press/release; held otherwise
//   overflow       out  make dropped because the table was full
module ps2_key_tracker #(
   parameter int unsigned CLOCK_FREQUENCY   = 25000000,
   parameter int unsigned SLOTS             = 4,
   parameter int unsigned PREFIX_TIMEOUT_MS = 2
) (
   input  logic               Clock,
   input  logic               reset,
   input  logic               byte_valid,
   input  logic [7:0]         byte_data,
   input  logic               clear,
   output logic [SLOTS*9-1:0] held_codes,
   output logic [SLOTS-1:0]   held_valid,
   output logic               any_held,
   output logic               press_pulse,
   output logic               release_pulse,
   output logic [8:0]         event_code,
   output logic               overflow
);

   localparam int unsigned TIMEOUT_RAW    = CLOCK_FREQUENCY / 1000 * PREFIX_TIMEOUT_MS;
   localparam int unsigned TIMEOUT_CYCLES = (TIMEOUT_RAW < 1) ? 1 : TIMEOUT_RAW;
   localparam int unsigned TW             = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StSkip} state_e;

   state_e             state_q, state_d;
   logic [2:0]         skip_q, skip_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [SLOTS*9-1:0] codes_q, codes_d;
   logic [SLOTS-1:0]   valid_q, valid_d;
   logic               any_q, any_d;
   logic               press_q, press_d;
   logic               release_q, release_d;
   logic               overflow_q, overflow_d;
   logic [8:0]         event_q, event_d;

   logic               do_make, do_break;
   logic [8:0]         dec_code;
   logic               hit, free;
   int                 hit_idx, free_idx;

   // Protocol bytes (ACK, BAT, echo, errors) that never start a key sequence.
   function automatic logic is_ignored(input logic [7:0] b);
      return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
             (b == 8'hFC) || (b == 8'hFD) || (b == 8'hFE) || (b == 8'hFF);
   endfunction

   // Fake-shift codes the keyboard wraps around some extended keys.
   function automatic logic is_fake_shift(input logic [7:0] b);
      return (b == 8'h12) || (b == 8'h59);
   endfunction

   // Sequence decoder and prefix timeout.
   always_comb begin
      state_d  = state_q;
      skip_d   = skip_q;
      do_make  = 1'b0;
      do_break = 1'b0;
      dec_code = {1'b0, byte_data};
      if (byte_valid) begin
         unique case (state_q)
            StIdle: begin
               if (byte_data == 8'hE0) begin
                  state_d = StExt;
               end else if (byte_data == 8'hF0) begin
                  state_d = StBrk;
               end else if (byte_data == 8'hE1) begin
                  state_d = StSkip;
                  skip_d  = 3'd7;
               end else if (!is_ignored(byte_data)) begin
                  do_make = 1'b1;
               end
            end
            StExt: begin
               if (byte_data == 8'hF0) begin
                  state_d = StExtBrk;
               end else begin
                  state_d  = StIdle;
                  dec_code = {1'b1, byte_data};
                  do_make  = !is_fake_shift(byte_data);
               end
            end
            StBrk: begin
               state_d  = StIdle;
               do_break = 1'b1;
            end
            StExtBrk: begin
               state_d  = StIdle;
               dec_code = {1'b1, byte_data};
               do_break = !is_fake_shift(byte_data);
            end
            StSkip: begin
               skip_d = skip_q - 3'd1;
               if (skip_q <= 3'd1) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end else if ((state_q != StIdle) && (timer_q >= TW'(TIMEOUT_CYCLES - 1))) begin
         state_d = StIdle;
      end

      if (clear) begin
         state_d  = StIdle;
         skip_d   = 3'd0;
         do_make  = 1'b0;
         do_break = 1'b0;
      end

      // Timer measures silence inside a sequence only.
      if (clear || byte_valid || (state_d == StIdle)) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TW'(1);
      end
   end

   // Held-key table: match and free-slot search, then update.
   always_comb begin
      codes_d    = codes_q;
      valid_d    = valid_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      overflow_d = 1'b0;
      event_d    = event_q;
      hit        = 1'b0;
      free       = 1'b0;
      hit_idx    = 0;
      free_idx   = 0;

      // Descending scan so the lowest index wins.
      for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
         if (valid_q[i] && (codes_q[9*i +: 9] == dec_code)) begin
            hit     = 1'b1;
            hit_idx = i;
         end
         if (!valid_q[i]) begin
            free     = 1'b1;
            free_idx = i;
         end
      end

      if (do_make) begin
         if (hit) begin
`ifdef TYPEMATIC_FILTER_EN
            press_d = 1'b0;
`else
            press_d = 1'b1;
            event_d = dec_code;
`endif
         end else if (free) begin
            codes_d[9*free_idx +: 9] = dec_code;
            valid_d[free_idx]        = 1'b1;
            press_d                  = 1'b1;
            event_d                  = dec_code;
         end else begin
            overflow_d = 1'b1;
         end
      end else if (do_break && hit) begin
         codes_d[9*hit_idx +: 9] = 9'h000;
         valid_d[hit_idx]        = 1'b0;
         release_d               = 1'b1;
         event_d                 = dec_code;
      end

      if (clear) begin
         codes_d    = '0;
         valid_d    = '0;
         press_d    = 1'b0;
         release_d  = 1'b0;
         overflow_d = 1'b0;
      end

      any_d = |valid_d;
   end

   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         skip_q     <= 3'd0;
         timer_q    <= '0;
         codes_q    <= '0;
         valid_q    <= '0;
         any_q      <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         overflow_q <= 1'b0;
         event_q    <= 9'h000;
      end else begin
         state_q    <= state_d;
         skip_q     <= skip_d;
         timer_q    <= timer_d;
         codes_q    <= codes_d;
         valid_q    <= valid_d;
         any_q      <= any_d;
         press_q    <= press_d;
         release_q  <= release_d;
         overflow_q <= overflow_d;
         event_q    <= event_d;
      end
   end

   assign held_codes    = codes_q;
   assign held_valid    = valid_q;
   assign any_held      = any_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign event_code    = event_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;

   localparam logic [1:0] EV_NONE  = 2'd0;
   localparam logic [1:0] EV_PRESS = 2'd1;
   localparam logic [1:0] EV_REL   = 2'd2;
   localparam logic [1:0] EV_OVF   = 2'd3;
`ifdef TYPEMATIC_FILTER_EN
   localparam logic [1:0] EV_REP   = EV_NONE;
`else
   localparam logic [1:0] EV_REP   = EV_PRESS;
`endif

   logic        Clock;
   logic        reset;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        clear;
   logic [35:0] held_codes;
   logic [3:0]  held_valid;
   logic        any_held;
   logic        press_pulse;
   logic        release_pulse;
   logic [8:0]  event_code;
   logic        overflow;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      int         gap;
      logic [7:0] b;
      logic [1:0] ev;
      logic [8:0] code;
      logic [3:0] hv;
   } vec_t;

   vec_t        vecs[$];
   logic [10:0] exp_q[$];

   ps2_key_tracker #(
      .CLOCK_FREQUENCY  (100000),
      .SLOTS            (4),
      .PREFIX_TIMEOUT_MS(2)
   ) dut (
      .Clock        (Clock),
      .reset        (reset),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .clear        (clear),
      .held_codes   (held_codes),
      .held_valid   (held_valid),
      .any_held     (any_held),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .event_code   (event_code),
      .overflow     (overflow)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t v(input int gap, input logic [7:0] b, input logic [1:0] ev,
                              input logic [8:0] code, input logic [3:0] hv);
      vec_t r;
      r.gap  = gap;
      r.b    = b;
      r.ev   = ev;
      r.code = code;
      r.hv   = hv;
      return r;
   endfunction

   // One byte strobe; expected event goes to the scoreboard when driven.
   task automatic send(input logic [7:0] b, input logic [1:0] ev, input logic [8:0] code);
      @(negedge Clock);
      if (ev != EV_NONE) exp_q.push_back({ev, code});
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge Clock);
      byte_valid = 1'b0;
   endtask

   // Event monitor: every pulse must match the oldest outstanding expectation.
   always @(negedge Clock) begin
      logic [1:0]  kind;
      logic [10:0] e;
      if (reset && (press_pulse || release_pulse || overflow)) begin
         if ($countones({press_pulse, release_pulse, overflow}) > 1)
            check("pulse_exclusive", {press_pulse, release_pulse, overflow}, 3'b000);
         kind = press_pulse ? EV_PRESS : (release_pulse ? EV_REL : EV_OVF);
         if (exp_q.size() == 0) begin
            check("unexpected_event", {kind, event_code}, 11'h000);
         end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e[10:9]);
            if (kind != EV_OVF) check("event_code", event_code, e[8:0]);
         end
      end
   end

   initial begin
      reset      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      clear      = 1'b0;

      // Test 1: single make/break
      vecs.push_back(v(0, 8'h29, EV_PRESS, 9'h029, 4'b0001));
      vecs.push_back(v(0, 8'hF0, EV_NONE,  9'h000, 4'b0001));
      vecs.push_back(v(0, 8'h29, EV_REL,   9'h029, 4'b0000));
      // Test 2: extended key and fake shift
      vecs.push_back(v(0, 8'hE0, EV_NONE,  9'h000, 4'b0000));
      vecs.push_back(v(0, 8'h75, EV_PRESS, 9'h175, 4'b0001));
      vecs.push_back(v(0, 8'hE0, EV_NONE,  9'h000, 4'b0001));
      vecs.push_back(v(0, 8'hF0, EV_NONE,  9'h000, 4'b0001));
      vecs.push_back(v(0, 8'h75, EV_REL,   9'h175, 4'b0000));
      vecs.push_back(v(0, 8'hE0, EV_NONE,  9'h000, 4'b0000));
      vecs.push_back(v(0, 8'h12, EV_NONE,  9'h000, 4'b0000));
      // Ignored protocol bytes and orphan break
      vecs.push_back(v(0, 8'hAA, EV_NONE,  9'h000, 4'b0000));
      vecs.push_back(v(0, 8'hFA, EV_NONE,  9'h000, 4'b0000));
      vecs.push_back(v(0, 8'hF0, EV_NONE,  9'h000, 4'b0000));
      vecs.push_back(v(0, 8'h5A, EV_NONE,  9'h000, 4'b0000));
      // Test 3: fill table, overflow, refill freed slot
      vecs.push_back(v(0, 8'h1C, EV_PRESS, 9'h01C, 4'b0001));
      vecs.push_back(v(0, 8'h1B, EV_PRESS, 9'h01B, 4'b0011));
      vecs.push_back(v(0, 8'h23, EV_PRESS, 9'h023, 4'b0111));
      vecs.push_back(v(0, 8'h2B, EV_PRESS, 9'h02B, 4'b1111));
      vecs.push_back(v(0, 8'h34, EV_OVF,   9'h034, 4'b1111));
      vecs.push_back(v(0, 8'hF0, EV_NONE,  9'h000, 4'b1111));
      vecs.push_back(v(0, 8'h1B, EV_REL,   9'h01B, 4'b1101));
      vecs.push_back(v(0, 8'h34, EV_PRESS, 9'h034, 4'b1111));

      reset = 1'b0;
      repeat (3) @(negedge Clock);
      check("rst_held_codes", held_codes, 36'h0);
      check("rst_held_valid", held_valid, 4'h0);
      check("rst_any_held", any_held, 1'b0);
      check("rst_press", press_pulse, 1'b0);
      check("rst_release", release_pulse, 1'b0);
      check("rst_event_code", event_code, 9'h000);
      check("rst_overflow", overflow, 1'b0);
      reset = 1'b1;

      foreach (vecs[k]) begin
         repeat (vecs[k].gap) @(negedge Clock);
         send(vecs[k].b, vecs[k].ev, vecs[k].code);
         check($sformatf("vec%0d_held_valid", k), held_valid, vecs[k].hv);
      end
      check("t3_held_codes", held_codes, {9'h02B, 9'h023, 9'h034, 9'h01C});
      check("t3_any_held", any_held, 1'b1);

      // Release all; other slots must stay in place
      send(8'hF0, EV_NONE, 9'h0);  send(8'h1C, EV_REL, 9'h01C);
      check("t3_rel0_hv", held_valid, 4'b1110);
      send(8'hF0, EV_NONE, 9'h0);  send(8'h23, EV_REL, 9'h023);
      check("t3_rel2_codes", held_codes, {9'h02B, 9'h000, 9'h034, 9'h000});
      send(8'hF0, EV_NONE, 9'h0);  send(8'h2B, EV_REL, 9'h02B);
      send(8'hF0, EV_NONE, 9'h0);  send(8'h34, EV_REL, 9'h034);
      check("t3_empty_any", any_held, 1'b0);

      // Test 4: typematic repeats
      send(8'h29, EV_PRESS, 9'h029);
      send(8'h29, EV_REP, 9'h029);
      send(8'h29, EV_REP, 9'h029);
      check("t4_held_valid", held_valid, 4'b0001);
      send(8'hF0, EV_NONE, 9'h0);  send(8'h29, EV_REL, 9'h029);

      // Test 5: short gap keeps the break prefix; long gap drops it
      send(8'h29, EV_PRESS, 9'h029);
      send(8'hF0, EV_NONE, 9'h0);
      repeat (50) @(negedge Clock);
      send(8'h29, EV_REL, 9'h029);
      check("t5_short_gap_hv", held_valid, 4'b0000);
      send(8'hF0, EV_NONE, 9'h0);
      repeat (250) @(negedge Clock);
      send(8'h29, EV_PRESS, 9'h029);
      check("t5_timeout_hv", held_valid, 4'b0001);
      check("t5_timeout_code", held_codes, {27'h0, 9'h029});
      send(8'hF0, EV_NONE, 9'h0);  send(8'h29, EV_REL, 9'h029);

      // Test 6: pause sequence is swallowed, then decoding resumes
      begin
         logic [7:0] pause_seq[8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
         foreach (pause_seq[k]) send(pause_seq[k], EV_NONE, 9'h0);
      end
      check("t6_pause_hv", held_valid, 4'b0000);
      send(8'h1C, EV_PRESS, 9'h01C);
      send(8'hF0, EV_NONE, 9'h0);  send(8'h1C, EV_REL, 9'h01C);

      // Clear together with a byte: byte discarded, table flushed, no releases
      send(8'h29, EV_PRESS, 9'h029);
      send(8'h1B, EV_PRESS, 9'h01B);
      @(negedge Clock);
      clear      = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'h1C;
      @(negedge Clock);
      clear      = 1'b0;
      byte_valid = 1'b0;
      check("clr_held_valid", held_valid, 4'b0000);
      check("clr_any_held", any_held, 1'b0);
      // Clear also resets the decoder mid-sequence
      send(8'hE0, EV_NONE, 9'h0);
      @(negedge Clock);
      clear = 1'b1;
      @(negedge Clock);
      clear = 1'b0;
      send(8'h75, EV_PRESS, 9'h075);
      send(8'hF0, EV_NONE, 9'h0);  send(8'h75, EV_REL, 9'h075);

      // Async reset mid-EXT
      send(8'h29, EV_PRESS, 9'h029);
      send(8'hE0, EV_NONE, 9'h0);
      #2 reset = 1'b0;
      #1;
      check("arst_held_valid", held_valid, 4'b0000);
      check("arst_held_codes", held_codes, 36'h0);
      check("arst_any_held", any_held, 1'b0);
      check("arst_event_code", event_code, 9'h000);
      @(negedge Clock);
      reset = 1'b1;
      send(8'h75, EV_PRESS, 9'h075);
      check("arst_after_hv", held_valid, 4'b0001);
      send(8'hF0, EV_NONE, 9'h0);  send(8'h75, EV_REL, 9'h075);

      repeat (3) @(negedge Clock);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
